// File: rtl/vga_sincronismo.sv
// vga_sincronismo: autonomous 640x480 VGA timing generator.
// A clk divider produces one pixel tick every DIVISOR clk cycles. On each tick
// the (linha, coluna) raster position advances, and hsync/vsync/areaAtiva are
// registered from the *next* position, so they always match the position
// presented in the same cycle.
module vga_sincronismo #(
    parameter int DIVISOR = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       areaAtiva,
    output logic [9:0] linha,
    output logic [9:0] coluna,
    output logic       pixel_en,
    output logic       frame_start
);

    localparam logic [3:0] DIV_LAST   = 4'(DIVISOR - 1);

    localparam logic [9:0] H_LAST     = 10'd799;
    localparam logic [9:0] H_VIS      = 10'd640;
    localparam logic [9:0] H_SYNC_INI = 10'd656;
    localparam logic [9:0] H_SYNC_FIM = 10'd751;

    localparam logic [9:0] V_LAST     = 10'd524;
    localparam logic [9:0] V_VIS      = 10'd480;
    localparam logic [9:0] V_SYNC_INI = 10'd490;
    localparam logic [9:0] V_SYNC_FIM = 10'd491;

    logic [3:0] divCnt;
    logic       tick;
    logic       fimLinha;
    logic       fimQuadro;
    logic [9:0] linhaProx;
    logic [9:0] colunaProx;
    logic       hsyncProx;
    logic       vsyncProx;
    logic       areaProx;

    // Tick decode and next-position arithmetic; '>=' compares keep the
    // counters self-correcting should they ever leave their ranges.
    always_comb begin
        tick       = (divCnt >= DIV_LAST);
        fimLinha   = (linha >= H_LAST);
        fimQuadro  = fimLinha && (coluna >= V_LAST);
        linhaProx  = fimLinha ? 10'd0 : linha + 10'd1;
        colunaProx = coluna;
        if (fimLinha) begin
            colunaProx = (coluna >= V_LAST) ? 10'd0 : coluna + 10'd1;
        end
        hsyncProx  = !((linhaProx >= H_SYNC_INI) && (linhaProx <= H_SYNC_FIM));
        vsyncProx  = !((colunaProx >= V_SYNC_INI) && (colunaProx <= V_SYNC_FIM));
        areaProx   = (linhaProx < H_VIS) && (colunaProx < V_VIS);
    end

    // Divider, raster position and registered sync/area outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt      <= 4'd0;
            linha       <= 10'd0;
            coluna      <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            areaAtiva   <= 1'b0;
            pixel_en    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            divCnt      <= tick ? 4'd0 : divCnt + 4'd1;
            pixel_en    <= tick;
            frame_start <= tick && fimQuadro;
            if (tick) begin
                linha     <= linhaProx;
                coluna    <= colunaProx;
                hsync     <= hsyncProx;
                vsync     <= vsyncProx;
                areaAtiva <= areaProx;
            end
        end
    end

endmodule

// File: tb/tb_vga_sincronismo.sv
// tb_vga_sincronismo: two instances (DIVISOR=2 and DIVISOR=1) checked every
// clk against a raster model derived from the elapsed clk count.
`timescale 1ns/1ps
module tb_vga_sincronismo;

    logic clk = 1'b0;
    logic rstA_n = 1'b0;
    logic rstB_n = 1'b0;

    logic       hsA, vsA, aaA, peA, fsA;
    logic [9:0] linA, colA;
    logic       hsB, vsB, aaB, peB, fsB;
    logic [9:0] linB, colB;

    int total = 0;
    int bad   = 0;

    // clk edges seen since each reset was released
    int nA = 0;
    int nB = 0;

    // frame measurements on the DIVISOR=1 instance
    int  actB    = 0;
    int  vsLowB  = 0;
    int  fsNB    = 0;
    int  wrapNB  = 0;
    bit  bDone   = 1'b0;

    vga_sincronismo #(.DIVISOR(2)) u_div2 (
        .clk(clk), .rst_n(rstA_n), .hsync(hsA), .vsync(vsA), .areaAtiva(aaA),
        .linha(linA), .coluna(colA), .pixel_en(peA), .frame_start(fsA)
    );

    vga_sincronismo #(.DIVISOR(1)) u_div1 (
        .clk(clk), .rst_n(rstB_n), .hsync(hsB), .vsync(vsB), .areaAtiva(aaB),
        .linha(linB), .coluna(colB), .pixel_en(peB), .frame_start(fsB)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
            if (bad > 200) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    endtask

    // Expected outputs after n clk edges out of reset:
    // n/d ticks have elapsed, each advancing the raster by one pixel.
    // Packing: {hsync, vsync, areaAtiva, linha, coluna, pixel_en, frame_start}
    function automatic logic [24:0] model(input int d, input int n);
        int t, p, lin, col;
        logic hs, vs, aa, pe, fs;
        t   = n / d;
        p   = t % 420000;
        lin = p % 800;
        col = p / 800;
        pe  = (n > 0) && (n % d == 0);
        fs  = pe && (p == 0);
        hs  = !(lin >= 656 && lin <= 751);
        vs  = !(col >= 490 && col <= 491);
        aa  = (t > 0) && (lin < 640) && (col < 480);
        return {hs, vs, aa, 10'(lin), 10'(col), pe, fs};
    endfunction

    always @(posedge clk or negedge rstA_n)
        if (!rstA_n) nA <= 0; else nA <= nA + 1;

    always @(posedge clk or negedge rstB_n)
        if (!rstB_n) nB <= 0; else nB <= nB + 1;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cycle div2", 32'({hsA, vsA, aaA, linA, colA, peA, fsA}), 32'(model(2, nA)));
        chk("cycle div1", 32'({hsB, vsB, aaB, linB, colB, peB, fsB}), 32'(model(1, nB)));
    end

    // Frame statistics of the DIVISOR=1 instance up to its first frame_start.
    always @(negedge clk) begin
        if (rstB_n && !bDone) begin
            if (peB && aaB) actB <= actB + 1;
            if (!vsB) vsLowB <= vsLowB + 1;
            if (wrapNB == 0 && linB == 10'd0 && colB == 10'd1) wrapNB <= nB;
            if (fsB) begin
                bDone <= 1'b1;
                fsNB  <= nB;
            end
        end
    end

    initial begin
        int fallN, riseN, l1;
        rstA_n = 1'b0;
        rstB_n = 1'b0;

        repeat (5) begin
            @(posedge clk);
            #1;
            chk("reset div2", 32'({hsA, vsA, aaA, linA, colA, peA, fsA}), 32'(25'b1_1_0_0000000000_0000000000_0_0));
            chk("reset div1", 32'({hsB, vsB, aaB, linB, colB, peB, fsB}), 32'(25'b1_1_0_0000000000_0000000000_0_0));
        end

        @(negedge clk);
        rstA_n = 1'b1;
        rstB_n = 1'b1;

        @(posedge clk);
        #1;
        chk("div2 hold after 1 clk", 32'(linA), 32'd0);
        chk("div2 no pixel_en after 1 clk", 32'(peA), 32'd0);
        @(posedge clk);
        #1;
        chk("div2 first tick linha", 32'(linA), 32'd1);
        chk("div2 first tick area", 32'(aaA), 32'd1);
        chk("div2 first tick pixel_en", 32'(peA), 32'd1);
        chk("div2 no frame_start at release", 32'(fsA), 32'd0);
        chk("div1 linha after 2 clk", 32'(linB), 32'd2);

        // hsync window on the DIVISOR=2 instance
        for (int i = 0; i < 4000 && hsA; i++) @(negedge clk);
        chk("hsync fell", 32'(hsA), 32'd0);
        chk("hsync fall linha", 32'(linA), 32'd656);
        fallN = nA;
        for (int i = 0; i < 400 && !hsA; i++) @(negedge clk);
        riseN = nA;
        chk("hsync rose", 32'(hsA), 32'd1);
        chk("hsync rise linha", 32'(linA), 32'd752);
        chk("hsync low clk", 32'(riseN - fallN), 32'd192);

        // line period
        for (int i = 0; i < 4000 && !(linA == 10'd0 && colA == 10'd1); i++) @(negedge clk);
        chk("line1 start clk", 32'(nA), 32'd1600);
        l1 = nA;
        for (int i = 0; i < 4000 && !(linA == 10'd0 && colA == 10'd2); i++) @(negedge clk);
        chk("line period clk", 32'(nA - l1), 32'd1600);

        // asynchronous reset in the middle of an hsync pulse
        for (int i = 0; i < 6000 && !(linA == 10'd700 && colA == 10'd3 && peA); i++) @(negedge clk);
        chk("reached 700,3", 32'({linA, colA}), 32'({10'd700, 10'd3}));
        chk("hsync low at 700", 32'(hsA), 32'd0);
        #5;
        rstA_n = 1'b0;
        #1;
        chk("midreset outputs", 32'({hsA, vsA, aaA, linA, colA, peA, fsA}), 32'(25'b1_1_0_0000000000_0000000000_0_0));
        repeat (3) @(negedge clk);
        rstA_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset hold", 32'(linA), 32'd0);
        @(posedge clk);
        #1;
        chk("midreset first tick", 32'(linA), 32'd1);
        chk("midreset pixel_en", 32'(peA), 32'd1);

        // full frame of the undivided instance
        for (int i = 0; i < 430000 && !bDone; i++) @(negedge clk);
        @(negedge clk);
        chk("div1 frame seen", 32'(bDone), 32'd1);
        chk("div1 frame_start clk", 32'(fsNB), 32'd420000);
        chk("div1 active ticks", 32'(actB), 32'd307200);
        chk("div1 vsync low clk", 32'(vsLowB), 32'd1600);
        chk("div1 line wrap clk", 32'(wrapNB), 32'd800);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
